freq_meter_bcd: RTL



---
 rtl/freq_meter_bcd.sv | 80 ++++++++
 1 files changed

// File: rtl/freq_meter_bcd.sv
// freq_meter_bcd: counts rising edges of sig_in over a GATE_CYCLES window and publishes packed BCD
//   clock     : system clock, rising edge
//   clear     : synchronous active-high reset
//   sig_in    : asynchronous measured signal
//   hold      : (FREQ_METER_HOLD_EN only) freeze published result at window end
//   count_bcd : latched result, digit 0 (units) in [3:0]
//   valid     : one-cycle pulse when count_bcd updates
//   overflow  : latched with count_bcd, window exceeded 10^DIGITS-1 edges
// Optional feature macro: FREQ_METER_HOLD_EN
module freq_meter_bcd #(
    parameter int GATE_CYCLES = 100000000,
    parameter int DIGITS      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                sig_in,
`ifdef FREQ_METER_HOLD_EN
    input  logic                hold,
`endif
    output logic [4*DIGITS-1:0] count_bcd,
    output logic                valid,
    output logic                overflow
);
    localparam int GW = $clog2(GATE_CYCLES);
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   edge_det;
    logic [GW-1:0]          gate;
    logic                   terminal;
    logic                   publish;
    logic [4*DIGITS-1:0]    acc;
    logic [4*DIGITS-1:0]    inc_acc;
    logic [4*DIGITS-1:0]    next_acc;
    logic                   carry;
    logic                   sat;
    logic                   pend;
    assign edge_det = sync[SYNC_STAGES-1] & ~prev;
    assign terminal = gate == GW'(GATE_CYCLES - 1);
`ifdef FREQ_METER_HOLD_EN
    assign publish = terminal & ~hold;
`else
    assign publish = terminal;
`endif
    // Ripple decade increment; the carry out of the top digit means all nines, i.e. saturation.
    always_comb begin
        carry   = edge_det;
        inc_acc = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) inc_acc[4*i +: 4] = (acc[4*i +: 4] == 4'd9) ? 4'd0 : acc[4*i +: 4] + 4'd1;
            carry = carry & (acc[4*i +: 4] == 4'd9);
        end
        sat      = carry;
        next_acc = sat ? acc : inc_acc;
    end
    always_ff @(posedge clock) begin
        if (clear) begin
            sync      <= '0;
            prev      <= 1'b0;
            gate      <= '0;
            acc       <= '0;
            pend      <= 1'b0;
            count_bcd <= '0;
            valid     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], sig_in};
            prev  <= sync[SYNC_STAGES-1];
            gate  <= terminal ? '0 : gate + 1'b1;
            // The edge present in the terminal cycle belongs to the closing window.
            acc   <= terminal ? '0 : next_acc;
            pend  <= terminal ? 1'b0 : pend | sat;
            valid <= publish;
            if (publish) begin
                count_bcd <= next_acc;
                overflow  <= pend | sat;
            end
        end
    end
endmodule
